// File: rtl/exe.sv
// Execute stage of the RV32IM pipeline: RV32I ALU, single-cycle multiplier and
// an iterative restoring divider that stalls the pipeline while it works.
//
// state | meaning
// IDLE  | no divide in flight; ALU/MUL/trivial divides resolve combinationally
// BUSY  | restoring division, one quotient bit per clock, stall raised
// DONE  | sign-corrected divide result presented, stall released
module exe #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [31:0]            inst_i,
    input  logic [DATA_WIDTH-1:0]  op1_i,
    input  logic [DATA_WIDTH-1:0]  op2_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   stall_req_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_alu, is_m, is_div, is_rem, div_signed;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign is_m   = (opcode == OP_REG) && (funct7 == 7'b0000001);
    assign is_alu = ((opcode == OP_REG) && !is_m) || (opcode == OP_IMM);
    assign is_div = is_m && funct3[2];
    assign is_rem = funct3[1];
    assign div_signed = ~funct3[0];

    // ALU
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    assign shamt = op2_i[4:0];

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = ((opcode == OP_REG) && inst_i[30]) ? op1_i - op2_i : op1_i + op2_i;
            3'b001: alu_res = op1_i << shamt;
            3'b010: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            3'b011: alu_res = {{(DATA_WIDTH-1){1'b0}}, op1_i < op2_i};
            3'b100: alu_res = op1_i ^ op2_i;
            3'b101: alu_res = inst_i[30] ? DATA_WIDTH'($signed(op1_i) >>> shamt) : op1_i >> shamt;
            3'b110: alu_res = op1_i | op2_i;
            default: alu_res = op1_i & op2_i;
        endcase
    end

    // Multiplier: sign- or zero-extend both operands so one unsigned product covers every form
    logic                      mul_sa, mul_sb;
    logic [2*DATA_WIDTH+1:0]   mul_a, mul_b, prod;
    logic [DATA_WIDTH-1:0]     mul_res;

    assign mul_sa  = (funct3 != 3'b011);
    assign mul_sb  = (funct3 == 3'b001);
    assign mul_a   = {{(DATA_WIDTH+2){mul_sa & op1_i[DATA_WIDTH-1]}}, op1_i};
    assign mul_b   = {{(DATA_WIDTH+2){mul_sb & op2_i[DATA_WIDTH-1]}}, op2_i};
    assign prod    = mul_a * mul_b;
    assign mul_res = (funct3 == 3'b000) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];

    // Divider
    logic                  op1_neg, op2_neg, div_zero, div_ovf, div_start;
    logic [DATA_WIDTH-1:0] op1_abs, op2_abs;

    assign op1_neg   = div_signed & op1_i[DATA_WIDTH-1];
    assign op2_neg   = div_signed & op2_i[DATA_WIDTH-1];
    assign op1_abs   = op1_neg ? -op1_i : op1_i;
    assign op2_abs   = op2_neg ? -op2_i : op2_i;
    assign div_zero  = (op2_i == '0);
    assign div_ovf   = div_signed && (op1_i == INT_MIN) && (op2_i == '1);
    assign div_start = is_div && !div_zero && !div_ovf && !flush_i;

    logic [1:0]            state, state_nx;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] quo_r, rem_r, dvs_r;
    logic                  neg_q_r, neg_r_r, rem_sel_r;

    logic [DATA_WIDTH:0]   rem_sh, rem_diff;
    logic                  step_ge;
    logic [DATA_WIDTH-1:0] q_out, r_out, div_res;

    assign rem_sh   = {rem_r, quo_r[DATA_WIDTH-1]};
    assign step_ge  = rem_sh >= {1'b0, dvs_r};
    assign rem_diff = rem_sh - {1'b0, dvs_r};
    assign q_out    = neg_q_r ? -quo_r : quo_r;
    assign r_out    = neg_r_r ? -rem_r : rem_r;
    assign div_res  = rem_sel_r ? r_out : q_out;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (state == IDLE && div_start) ? BUSY : IDLE;
            BUSY:    state_nx = (cnt == CW'(DIV_CYCLES - 1)) ? DONE : BUSY;
            default: state_nx = IDLE;
        endcase
        if (flush_i) state_nx = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            dvs_r     <= '0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            rem_sel_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && div_start) begin
                quo_r     <= op1_abs;
                rem_r     <= '0;
                dvs_r     <= op2_abs;
                neg_q_r   <= op1_neg ^ op2_neg;
                neg_r_r   <= op1_neg;
                rem_sel_r <= is_rem;
                cnt       <= '0;
            end else if (state == BUSY) begin
                quo_r <= {quo_r[DATA_WIDTH-2:0], step_ge};
                rem_r <= step_ge ? rem_diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
                cnt   <= cnt + CW'(1);
            end
        end
    end

    // Output select; flush and reset override everything so no partial result escapes
    always_comb begin
        reg_wdata_o = '0;
        reg_we_o    = 1'b0;
        stall_req_o = 1'b0;
        if (state == BUSY) begin
            stall_req_o = 1'b1;
        end else if (state == DONE) begin
            reg_wdata_o = div_res;
            reg_we_o    = reg_we_i;
        end else if (is_div) begin
            if (div_zero) begin
                reg_wdata_o = is_rem ? op1_i : '1;
                reg_we_o    = reg_we_i;
            end else if (div_ovf) begin
                reg_wdata_o = is_rem ? '0 : INT_MIN;
                reg_we_o    = reg_we_i;
            end else begin
                stall_req_o = 1'b1;
            end
        end else if (is_m) begin
            reg_wdata_o = mul_res;
            reg_we_o    = reg_we_i;
        end else if (is_alu) begin
            reg_wdata_o = alu_res;
            reg_we_o    = reg_we_i;
        end
        if (flush_i) begin
            stall_req_o = 1'b0;
            reg_we_o    = 1'b0;
        end
        if (!rst_n_i) begin
            reg_wdata_o = '0;
            reg_we_o    = 1'b0;
            stall_req_o = 1'b0;
        end
    end

    assign reg_waddr_o = rst_n_i ? reg_waddr_i : '0;

    logic unused_bits;
    assign unused_bits = ^{inst_i[24:15], inst_i[11:7], prod[2*DATA_WIDTH+1:2*DATA_WIDTH]};

endmodule
